// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM (negedge write,
// posedge registered read). Burst ownership is capped at MAX_BURST beats under contention.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_st,
  output logic [DATA_WIDTH-1:0] ram_x,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  localparam logic [3:0] LP_MAX = MAX_BURST[3:0];

  logic       r_owner;
  logic [3:0] r_cnt;
  logic       r_rsp_pend;
  logic       r_rsp_id;

  logic       w_gnt_valid;
  logic       w_gnt_id;
  logic       w_gnt_we;
  logic       w_burst_hold;

  assign w_burst_hold = (r_cnt != 4'd0) && (r_cnt < LP_MAX);

  // Grant decision; forced idle while reset is asserted so nothing reaches the RAM.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_id    = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = w_burst_hold ? r_owner : ~r_owner;
      end else if (req0_valid) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = 1'b0;
      end else if (req1_valid) begin
        w_gnt_valid = 1'b1;
        w_gnt_id    = 1'b1;
      end
    end
  end

  assign w_gnt_we   = w_gnt_id ? req1_we : req0_we;
  assign req0_ready = w_gnt_valid && !w_gnt_id;
  assign req1_ready = w_gnt_valid && w_gnt_id;

  always_comb begin
    ram_addr = req0_addr;
    ram_x    = '0;
    ram_st   = 1'b0;
    if (w_gnt_valid) begin
      ram_addr = w_gnt_id ? req1_addr : req0_addr;
      ram_x    = w_gnt_id ? req1_wdata : req0_wdata;
      ram_st   = w_gnt_we;
    end
  end

  // Owner/count survive idle only as the pointer; the count restarts so ~owner wins next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= 1'b1;
      r_cnt      <= 4'd0;
      r_rsp_pend <= 1'b0;
      r_rsp_id   <= 1'b0;
    end else begin
      if (w_gnt_valid) begin
        if (w_gnt_id == r_owner) begin
          r_cnt <= (r_cnt >= LP_MAX) ? LP_MAX : r_cnt + 4'd1;
        end else begin
          r_owner <= w_gnt_id;
          r_cnt   <= 4'd1;
        end
      end else begin
        r_cnt <= 4'd0;
      end
      r_rsp_pend <= w_gnt_valid && !w_gnt_we;
      r_rsp_id   <= w_gnt_id;
    end
  end

  // RAM output register already holds the addressed word, so data passes straight through.
  always_comb begin
    rsp0_valid = r_rsp_pend && !r_rsp_id;
    rsp1_valid = r_rsp_pend && r_rsp_id;
    rsp0_rdata = rsp0_valid ? ram_out : '0;
    rsp1_rdata = rsp1_valid ? ram_out : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM (negedge write, posedge read).
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_we;
  logic [5:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       rsp0_valid;
  logic [7:0] rsp0_rdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [5:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp1_valid;
  logic [7:0] rsp1_rdata;
  logic [5:0] ram_addr;
  logic       ram_st;
  logic [7:0] ram_x;
  logic [7:0] ram_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [64];

  always #5 clk = ~clk;

  always @(negedge clk) if (ram_st) mem[ram_addr] <= ram_x;
  always @(posedge clk) ram_out <= mem[ram_addr];

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_addr(ram_addr), .ram_st(ram_st), .ram_x(ram_x), .ram_out(ram_out)
  );

  // Initial RAM contents are addr ^ 0x3C.
  function automatic logic [7:0] init_word(input logic [5:0] a);
    return {2'b00, a} ^ 8'h3C;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    rst = 1;
    #2;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    req0_valid = 1; req0_we = 1; req0_addr = 6'h01; req0_wdata = 8'hEE;
    req1_valid = 1; req1_we = 1; req1_addr = 6'h02; req1_wdata = 8'hDD;
    @(negedge clk);
    if ({req0_ready, req1_ready, ram_st} !== 3'b000) begin
      $display("FAIL reset_hold rdy0/rdy1/st=%b want 000", {req0_ready, req1_ready, ram_st});
      n_bad++;
    end
    n_cmp++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      $display("FAIL reset_rsp got %b want 00", {rsp0_valid, rsp1_valid});
      n_bad++;
    end
    n_cmp++;
    step();
    rst = 0;
    req0_we = 0; req1_we = 0; req0_addr = 6'h00;
    @(negedge clk);
    if ({req0_ready, req1_ready, ram_st} !== 3'b100) begin
      $display("FAIL reset_release rdy0/rdy1/st=%b want 100", {req0_ready, req1_ready, ram_st});
      n_bad++;
    end
    n_cmp++;
    step();
    idle_inputs();
    @(negedge clk);
    if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {2'b10, 8'h3C}) begin
      $display("FAIL reset_first_read got v=%b d=%h want v=10 d=3c", {rsp0_valid, rsp1_valid}, rsp0_rdata);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_write_read();
    do_reset();
    step();
    req0_valid = 1; req0_we = 1; req0_addr = 6'h05; req0_wdata = 8'hA5;
    req1_valid = 1; req1_we = 0; req1_addr = 6'h05;
    @(negedge clk);
    if ({req0_ready, req1_ready, ram_st, ram_addr, ram_x} !== {3'b101, 6'h05, 8'hA5}) begin
      $display("FAIL wr_cycle1 rdy/st=%b addr=%h x=%h want 101 05 a5",
               {req0_ready, req1_ready, ram_st}, ram_addr, ram_x);
      n_bad++;
    end
    n_cmp++;
    step();
    req0_valid = 0; req0_we = 0;
    @(negedge clk);
    if ({req0_ready, req1_ready, ram_st, rsp0_valid, rsp1_valid} !== 5'b01000) begin
      $display("FAIL wr_cycle2 rdy/st/rspv=%b want 01000",
               {req0_ready, req1_ready, ram_st, rsp0_valid, rsp1_valid});
      n_bad++;
    end
    n_cmp++;
    step();
    req1_valid = 0;
    @(negedge clk);
    if ({rsp0_valid, rsp1_valid, rsp1_rdata, rsp0_rdata} !== {2'b01, 8'hA5, 8'h00}) begin
      $display("FAIL wr_cycle3 v=%b d1=%h d0=%h want 01 a5 00",
               {rsp0_valid, rsp1_valid}, rsp1_rdata, rsp0_rdata);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_contention();
    int exp_g [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic [7:0] exp_d;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      req0_valid = 1; req0_we = 0; req0_addr = 6'h10;
      req1_valid = 1; req1_we = 0; req1_addr = 6'h20;
      @(negedge clk);
      if ({req0_ready, req1_ready} !== ((exp_g[k] == 0) ? 2'b10 : 2'b01)) begin
        $display("FAIL rr_grant[%0d] rdy=%b want grant %0d", k, {req0_ready, req1_ready}, exp_g[k]);
        n_bad++;
      end
      n_cmp++;
      if (k > 0) begin
        exp_d = (exp_g[k-1] == 0) ? 8'h2C : 8'h1C;
        if ({rsp0_valid, rsp1_valid, rsp0_rdata | rsp1_rdata} !==
            {((exp_g[k-1] == 0) ? 2'b10 : 2'b01), exp_d}) begin
          $display("FAIL rr_rsp[%0d] v=%b d=%h want id %0d d=%h", k, {rsp0_valid, rsp1_valid},
                   rsp0_rdata | rsp1_rdata, exp_g[k-1], exp_d);
          n_bad++;
        end
        n_cmp++;
      end
    end
    step();
    idle_inputs();
    @(negedge clk);
    if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {2'b10, 8'h2C}) begin
      $display("FAIL rr_last_rsp v=%b d=%h want 10 2c", {rsp0_valid, rsp1_valid}, rsp0_rdata);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 67; i++) begin
      step();
      req1_valid = 1; req1_we = 0; req1_addr = (i < 64) ? 6'(i) : 6'h00;
      @(negedge clk);
      if ({req0_ready, req1_ready} !== 2'b01) begin
        $display("FAIL b2b_grant[%0d] rdy=%b want 01", i, {req0_ready, req1_ready});
        n_bad++;
      end
      n_cmp++;
      if (i > 0) begin
        exp_d = (i - 1 < 64) ? (((i - 1) == 5) ? 8'hA5 : init_word(6'(i - 1))) : 8'h3C;
        if ({rsp0_valid, rsp1_valid, rsp1_rdata} !== {2'b01, exp_d}) begin
          $display("FAIL b2b_rsp[%0d] v=%b d=%h want 01 %h", i - 1, {rsp0_valid, rsp1_valid},
                   rsp1_rdata, exp_d);
          n_bad++;
        end
        n_cmp++;
      end
    end
    // Count must have saturated at MAX_BURST, so the waiting requester now wins.
    step();
    req0_valid = 1; req0_we = 0; req0_addr = 6'h01;
    @(negedge clk);
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL b2b_saturate rdy=%b want 10", {req0_ready, req1_ready});
      n_bad++;
    end
    n_cmp++;
    step();
    idle_inputs();
    @(negedge clk);
    if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {2'b10, 8'h3D}) begin
      $display("FAIL b2b_final_rsp v=%b d=%h want 10 3d", {rsp0_valid, rsp1_valid}, rsp0_rdata);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_idle_gap();
    do_reset();
    step();
    req0_valid = 1; req0_addr = 6'h02;
    step();
    req0_valid = 0; req1_valid = 1; req1_addr = 6'h03;
    @(negedge clk);
    if ({req0_ready, req1_ready} !== 2'b01) begin
      $display("FAIL idle_pre rdy=%b want 01", {req0_ready, req1_ready});
      n_bad++;
    end
    n_cmp++;
    step();
    idle_inputs();
    @(negedge clk);
    if ({req0_ready, req1_ready, ram_st, ram_x} !== {3'b000, 8'h00}) begin
      $display("FAIL idle_none rdy/st=%b x=%h want 000 00", {req0_ready, req1_ready, ram_st}, ram_x);
      n_bad++;
    end
    n_cmp++;
    step();
    req0_valid = 1; req0_addr = 6'h04; req1_valid = 1; req1_addr = 6'h06;
    @(negedge clk);
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL idle_after rdy=%b want 10", {req0_ready, req1_ready});
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    step();
    req0_valid = 1; req0_we = 0; req0_addr = 6'h07;
    @(negedge clk);
    if (req0_ready !== 1'b1) begin
      $display("FAIL mid_accept rdy0=%b want 1", req0_ready);
      n_bad++;
    end
    n_cmp++;
    step();
    rst = 1;
    req0_valid = 0;
    req1_valid = 1; req1_we = 1; req1_addr = 6'h09; req1_wdata = 8'h77;
    #1;
    if ({rsp0_valid, rsp0_rdata, ram_st, req1_ready} !== {1'b0, 8'h00, 2'b00}) begin
      $display("FAIL mid_async v0=%b d0=%h st=%b rdy1=%b want 0 00 0 0",
               rsp0_valid, rsp0_rdata, ram_st, req1_ready);
      n_bad++;
    end
    n_cmp++;
    step();
    rst = 0;
    req1_we = 0; req1_addr = 6'h0A;
    req0_valid = 1; req0_addr = 6'h09;
    @(negedge clk);
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b1000) begin
      $display("FAIL mid_release rdy/rspv=%b want 1000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
      n_bad++;
    end
    n_cmp++;
    step();
    idle_inputs();
    @(negedge clk);
    if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {2'b10, 8'h35}) begin
      $display("FAIL mid_no_write v=%b d=%h want 10 35", {rsp0_valid, rsp1_valid}, rsp0_rdata);
      n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_word(6'(i));
    ram_out = 8'h00;
    idle_inputs();
    test_reset();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_idle_gap();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester round-robin arbiter for the shared single-port RAM (negedge write, posedge registered read). It multiplexes requester 0 (CPU datapath) and requester 1 (loader/debug port) onto the RAM's addr/st/x inputs and returns read data to the issuing requester. Bounded burst ownership (MAX_BURST beats) prevents starvation.

Parameters:
DATA_WIDTH  8  RAM word width
ADDR_WIDTH  6  RAM address width
MAX_BURST   4  max consecutive beats granted to one requester while the other waits; legal range 1..15

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_WIDTH  requester 0 address
req0_wdata  in  DATA_WIDTH  requester 0 write data
rsp0_valid  out  1  requester 0 read data valid
rsp0_rdata  out  DATA_WIDTH  requester 0 read data
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_st  out  1  to RAM st
ram_x  out  DATA_WIDTH  to RAM x
ram_out  in  DATA_WIDTH  from RAM out

Behaviour:
- Clock/reset: single clock clk. rst is asynchronous, active-high. All state is cleared on rst assertion, with no clock edge required.
- State:
  - owner: 1 bit, last-served requester. Reset value 1, so requester 0 wins the first tie.
  - cnt: consecutive beats granted to owner. Reset value 0.
  - rsp_pend: 1 bit. Reset value 0.
  - rsp_id: 1 bit. Reset value 0.
- Grant is combinational from the valid signals and the registered state, same cycle.
  - Only one valid: grant that requester.
  - Both valid, cnt != 0 and cnt < MAX_BURST: grant owner.
  - Both valid, otherwise: grant ~owner.
  - Neither valid: no grant.
- reqN_ready = grant to N. At most one ready is high per cycle. Both readies are 0 while rst is high.
- Accepted beat = valid & ready. Requesters hold valid and command stable until ready (requester obligation). The arbiter does not check this.
- RAM drive:
  - ram_addr = granted requester's addr. With no grant, ram_addr = req0_addr (don't-care, fixed for determinism).
  - ram_x = granted requester's wdata; 0 with no grant.
  - ram_st = granted & we. ram_st is 0 with no grant and 0 during rst.
- State update at posedge:
  - Grant to X == owner: cnt <= min(cnt+1, MAX_BURST).
  - Grant to X != owner: owner <= X, cnt <= 1.
  - No grant: cnt <= 0, owner unchanged (round-robin pointer retained across idle).
- Read latency: 1 cycle.
  - An accepted read in cycle N sets rsp_pend = 1 and rsp_id = X at the posedge ending cycle N.
  - In cycle N+1, rspX_valid = 1 and rspX_rdata = ram_out, passed through combinationally (RAM output register already holds ram[addr]).
  - The other requester's rsp_valid = 0.
  - rspN_rdata = 0 when rspN_valid = 0.
  - Back-to-back reads give one response per cycle, in order.
- Write: no response. ram_st pulses for the grant cycle only.
- Write-then-read same address in consecutive or the same RAM cycle: the RAM writes at negedge before the posedge read, so the read returns new data. No hazard logic.
- Reset mid-operation: pending response is dropped (rsp_pend = 0). A write whose negedge has not yet occurred is not performed, because ram_st goes to 0 immediately.
- MAX_BURST = 1: strict alternation under contention.
- A lone requester is granted every cycle indefinitely. cnt saturates and does not wrap.

Test Plan:
- Reset with both valid held high -> both readies 0 and ram_st 0 during rst. First cycle after release: req0_ready = 1.
- req0 writes addr 0x05 = 0xA5 in cycle 1; req1 reads addr 0x05 in cycles 1 and 2 -> req0 granted in cycle 1 (ram_st = 1). req1 granted in cycle 2. rsp1_valid = 1 with 0xA5 in cycle 3. rsp0_valid stays 0.
- Both continuously reading, MAX_BURST = 4 -> grant pattern 0,0,0,0,1,1,1,1,0… Each response arrives 1 cycle after its grant, tagged to the correct requester.
- req1 alone reads addrs 0x00..0x3F back-to-back -> 64 consecutive grants, cnt saturates at 4, 64 in-order responses with no bubbles.
- Idle gap: req1 served last, then one idle cycle, then both valid -> req0 granted (pointer retained, cnt = 0 selects ~owner).
- rst asserted the cycle after a req0 read is accepted -> rsp0_valid never asserts. After release, the arbiter returns to its reset state.
